// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: branch opcodes and the
// data-memory access FSM encoding.
package mem_stage_pkg;

  localparam logic [5:0] OpBeq = 6'b000100;
  localparam logic [5:0] OpBne = 6'b000101;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;

  logic        Dm_req;
  logic        Dm_we;
  logic [31:0] Dm_addr;
  logic [31:0] Dm_wdata;
  logic [31:0] Dm_rdata;
  logic        Dm_ack;

  modport master (
    output Dm_req, Dm_we, Dm_addr, Dm_wdata,
    input  Dm_rdata, Dm_ack
  );

  modport slave (
    input  Dm_req, Dm_we, Dm_addr, Dm_wdata,
    output Dm_rdata, Dm_ack
  );

endinterface

// File: rtl/mem_wb.sv
// MEM/WB pipeline register. When We is low the stage inserts a bubble: the
// register-write flag is cleared and every other field holds.
module mem_wb (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        We,
  input  logic        Wreg,
  input  logic        Reg2reg,
  input  logic [4:0]  Rd,
  input  logic [31:0] Alu,
  input  logic        Mdata_we,
  input  logic [31:0] Mdata,
  output logic        W_Wreg,
  output logic        W_Reg2reg,
  output logic [4:0]  W_Rd,
  output logic [31:0] W_Alu,
  output logic [31:0] W_Mdata
);

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      W_Wreg    <= 1'b0;
      W_Reg2reg <= 1'b0;
      W_Rd      <= '0;
      W_Alu     <= '0;
      W_Mdata   <= '0;
    end else if (We) begin
      W_Wreg    <= Wreg;
      W_Reg2reg <= Reg2reg;
      W_Rd      <= Rd;
      W_Alu     <= Alu;
      if (Mdata_we) W_Mdata <= Mdata;
    end else begin
      W_Wreg    <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory bus, stalls upstream while an
// access is outstanding, aborts on timeout and resolves beq/bne branches.
module mem_stage import mem_stage_pkg::*; #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [5:0]  M_Op,
  input  logic        M_Wreg,
  input  logic        M_Reg2reg,
  input  logic        M_Wmem,
  input  logic        M_Z,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Sdata_in,
  input  logic [4:0]  Rd_in,
  input  logic [31:0] Bpc_in,
  mem_stage_if.master dm,
  output logic        Stall,
  output logic        Branch_taken,
  output logic [31:0] Branch_pc,
  output logic        W_Wreg,
  output logic        W_Reg2reg,
  output logic [4:0]  W_Rd,
  output logic [31:0] W_Alu,
  output logic [31:0] W_Mdata,
  output logic        Bus_err
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bus_err_q;

  logic access, is_load, busy, dm_req, expiry, timed_out;

  // A store that also claims a load is handled as a pure store.
  assign access  = M_Wmem | (M_Wreg & ~M_Reg2reg);
  assign is_load = ~M_Wmem & M_Wreg & ~M_Reg2reg;
  assign busy    = (state_q == StBusy);
  assign dm_req  = busy | access;

  // The request cycle counts as the first waited cycle, so the abort lands
  // after TIMEOUT stalled cycles. A same-cycle ack still wins.
  assign expiry    = busy && (32'(cnt_q) == TIMEOUT - 1);
  assign timed_out = expiry & ~dm.Dm_ack;

  assign Stall = dm_req & ~dm.Dm_ack & ~expiry;

  assign dm.Dm_req   = dm_req;
  assign dm.Dm_we    = M_Wmem;
  assign dm.Dm_addr  = Addr_in;
  assign dm.Dm_wdata = Sdata_in;

  assign Branch_taken = ~Stall & (((M_Op == OpBeq) & M_Z) | ((M_Op == OpBne) & ~M_Z));
  assign Branch_pc    = Bpc_in;
  assign Bus_err      = bus_err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (access && !dm.Dm_ack) begin
          state_d = StBusy;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (dm.Dm_ack || expiry) state_d = StIdle;
        else                     cnt_d   = cnt_q + CntW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (timed_out) bus_err_q <= 1'b1;
    end
  end

  mem_wb u_mem_wb (
    .Clk       (Clk),
    .Clrn      (Clrn),
    .We        (~Stall),
    .Wreg      (M_Wreg & ~timed_out),
    .Reg2reg   (M_Reg2reg),
    .Rd        (Rd_in),
    .Alu       (Addr_in),
    .Mdata_we  (is_load & ~timed_out),
    .Mdata     (dm.Dm_rdata),
    .W_Wreg    (W_Wreg),
    .W_Reg2reg (W_Reg2reg),
    .W_Rd      (W_Rd),
    .W_Alu     (W_Alu),
    .W_Mdata   (W_Mdata)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues the expected bus and
// write-back behaviour of each access, a monitor checks it on the bus.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned Timeout = 4;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b0;
  logic [5:0]  M_Op;
  logic        M_Wreg, M_Reg2reg, M_Wmem, M_Z;
  logic [31:0] Addr_in, Sdata_in, Bpc_in;
  logic [4:0]  Rd_in;
  logic        Stall, Branch_taken, W_Wreg, W_Reg2reg, Bus_err;
  logic [31:0] Branch_pc, W_Alu, W_Mdata;
  logic [4:0]  W_Rd;

  mem_stage_if dm ();

  mem_stage #(.TIMEOUT(Timeout)) dut (
    .Clk          (Clk),
    .Clrn         (Clrn),
    .M_Op         (M_Op),
    .M_Wreg       (M_Wreg),
    .M_Reg2reg    (M_Reg2reg),
    .M_Wmem       (M_Wmem),
    .M_Z          (M_Z),
    .Addr_in      (Addr_in),
    .Sdata_in     (Sdata_in),
    .Rd_in        (Rd_in),
    .Bpc_in       (Bpc_in),
    .dm           (dm),
    .Stall        (Stall),
    .Branch_taken (Branch_taken),
    .Branch_pc    (Branch_pc),
    .W_Wreg       (W_Wreg),
    .W_Reg2reg    (W_Reg2reg),
    .W_Rd         (W_Rd),
    .W_Alu        (W_Alu),
    .W_Mdata      (W_Mdata),
    .Bus_err      (Bus_err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stalls;
    logic        w_wreg;
    logic [4:0]  w_rd;
    logic [31:0] w_alu;
    logic [31:0] w_mdata;
    logic        bus_err;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_mdata = '0;
  logic        exp_err = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endfunction

  function automatic void check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endfunction

  // Monitor: one scoreboard entry per memory access seen on the bus.
  initial begin
    exp_t cur;
    bit   cur_v;
    int   stall_cnt;
    cur_v     = 1'b0;
    stall_cnt = 0;
    forever begin
      @(negedge Clk);
      if (!Clrn) begin
        cur_v = 1'b0;
      end else if (dm.Dm_req) begin
        if (!cur_v) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_req: got Dm_req=1 at addr %h, want no request", dm.Dm_addr);
          end else begin
            cur       = sb.pop_front();
            cur_v     = 1'b1;
            stall_cnt = 0;
          end
        end
        if (cur_v) begin
          check1("dm_we", dm.Dm_we, cur.we);
          check("dm_addr", dm.Dm_addr, cur.addr);
          check("dm_wdata", dm.Dm_wdata, cur.wdata);
          if (Stall) begin
            stall_cnt++;
            if (stall_cnt > 1) check1("bubble_w_wreg", W_Wreg, 1'b0);
          end else begin
            check("stall_cycles", 32'(stall_cnt), 32'(cur.stalls));
            cur_v = 1'b0;
            @(posedge Clk);
            #1;
            check1("w_wreg", W_Wreg, cur.w_wreg);
            check("w_rd", 32'(W_Rd), 32'(cur.w_rd));
            check("w_alu", W_Alu, cur.w_alu);
            check("w_mdata", W_Mdata, cur.w_mdata);
            check1("bus_err", Bus_err, cur.bus_err);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000");
    $fatal(1);
  end

  task automatic idle();
    M_Op      = 6'd0;
    M_Wreg    = 1'b0;
    M_Reg2reg = 1'b1;
    M_Wmem    = 1'b0;
    M_Z       = 1'b0;
    Addr_in   = '0;
    Sdata_in  = '0;
    Rd_in     = '0;
    Bpc_in    = '0;
    dm.Dm_ack   = 1'b0;
    dm.Dm_rdata = '0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Issue one access; ack arrives ack_dly cycles after the request, or never if tmo.
  task automatic issue(input logic wreg, input logic r2r, input logic wmem,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input int ack_dly, input logic [31:0] rdata, input bit tmo,
                       input logic [5:0] op, input logic z, input logic exp_br);
    exp_t        e;
    bit          load;
    int          n;
    logic [31:0] prev;
    load = wreg & ~r2r & ~wmem;
    n    = tmo ? int'(Timeout) : ack_dly;
    prev = exp_mdata;
    if (load && !tmo) exp_mdata = rdata;
    if (tmo) exp_err = 1'b1;
    e.we      = wmem;
    e.addr    = addr;
    e.wdata   = wdata;
    e.stalls  = n;
    e.w_wreg  = tmo ? 1'b0 : wreg;
    e.w_rd    = rd;
    e.w_alu   = addr;
    e.w_mdata = exp_mdata;
    e.bus_err = exp_err;
    sb.push_back(e);
    M_Op = op; M_Z = z; Bpc_in = 32'h80;
    M_Wreg = wreg; M_Reg2reg = r2r; M_Wmem = wmem;
    Addr_in = addr; Sdata_in = wdata; Rd_in = rd;
    for (int k = 0; k <= n; k++) begin
      dm.Dm_ack   = !tmo && (k == n);
      dm.Dm_rdata = dm.Dm_ack ? rdata : (tmo ? prev : 32'hFFFF_0000 + 32'(k));
      if (k == 0 && op != 6'd0) begin
        #2;
        check1("branch_taken_mem", Branch_taken, exp_br);
        check("branch_pc_mem", Branch_pc, 32'h80);
      end
      step();
    end
    idle();
    step();
  endtask

  initial begin
    exp_t e;
    idle();
    Clrn = 1'b0;
    #12;
    check1("rst_w_wreg", W_Wreg, 1'b0);
    check1("rst_w_reg2reg", W_Reg2reg, 1'b0);
    check("rst_w_rd", 32'(W_Rd), 32'd0);
    check("rst_w_alu", W_Alu, 32'd0);
    check("rst_w_mdata", W_Mdata, 32'd0);
    check1("rst_bus_err", Bus_err, 1'b0);
    check1("rst_dm_req", dm.Dm_req, 1'b0);
    check1("rst_stall", Stall, 1'b0);
    @(negedge Clk);
    Clrn = 1'b1;
    step();
    step();

    // zero-wait load, multi-cycle store, 1-wait load, store+load, timeout, post-error load
    issue(1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        5'd5,  0, 32'hDEADBEEF, 1'b0, 6'd0, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 1'b1, 32'h200, 32'h12345678, 5'd3,  3, 32'h0,        1'b0, 6'd0, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 32'h300, 32'h0,        5'd7,  1, 32'hCAFEF00D, 1'b0, 6'd0, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 32'h340, 32'h11112222, 5'd8,  0, 32'h55555555, 1'b0, 6'd0, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 32'h400, 32'h0,        5'd9,  0, 32'h0,        1'b1, 6'd0, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 32'h500, 32'h0,        5'd10, 2, 32'h0BADF00D, 1'b0, 6'd0, 1'b0, 1'b0);

    // A stray ack with no request must not start or complete anything.
    dm.Dm_ack   = 1'b1;
    dm.Dm_rdata = 32'h77;
    #2;
    check1("stray_ack_req", dm.Dm_req, 1'b0);
    check1("stray_ack_stall", Stall, 1'b0);
    step();
    step();
    check1("stray_ack_w_wreg", W_Wreg, 1'b0);
    check("stray_ack_w_mdata", W_Mdata, 32'h0BADF00D);
    idle();
    step();

    // Branch resolution with no memory access.
    M_Op = OpBeq; M_Z = 1'b1; Bpc_in = 32'h40;
    #2;
    check1("beq_z1", Branch_taken, 1'b1);
    check("beq_pc", Branch_pc, 32'h40);
    M_Op = OpBne;
    #1;
    check1("bne_z1", Branch_taken, 1'b0);
    M_Z = 1'b0;
    #1;
    check1("bne_z0", Branch_taken, 1'b1);
    M_Op = OpBeq;
    #1;
    check1("beq_z0", Branch_taken, 1'b0);
    idle();
    step();

    // Branch gated by a stalled access, then taken alongside a zero-wait access.
    issue(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 5'd11, 1, 32'h600D600D, 1'b0, OpBeq, 1'b1, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 32'h640, 32'h0, 5'd12, 0, 32'h00001234, 1'b0, OpBne, 1'b0, 1'b1);

    // Reset in the middle of a stalled store.
    e.we = 1'b1; e.addr = 32'h700; e.wdata = 32'hA5A5A5A5; e.stalls = 99;
    e.w_wreg = 1'b0; e.w_rd = 5'd13; e.w_alu = 32'h700; e.w_mdata = '0; e.bus_err = 1'b0;
    sb.push_back(e);
    M_Wmem = 1'b1; M_Wreg = 1'b1; M_Reg2reg = 1'b1;
    Addr_in = 32'h700; Sdata_in = 32'hA5A5A5A5; Rd_in = 5'd13;
    step();
    step();
    #2;
    Clrn = 1'b0;
    idle();
    #1;
    check1("midrst_w_wreg", W_Wreg, 1'b0);
    check1("midrst_w_reg2reg", W_Reg2reg, 1'b0);
    check("midrst_w_rd", 32'(W_Rd), 32'd0);
    check("midrst_w_alu", W_Alu, 32'd0);
    check("midrst_w_mdata", W_Mdata, 32'd0);
    check1("midrst_bus_err", Bus_err, 1'b0);
    check1("midrst_dm_req", dm.Dm_req, 1'b0);
    check1("midrst_stall", Stall, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Clrn = 1'b1;
    step();
    step();
    check1("post_rst_w_wreg", W_Wreg, 1'b0);
    check1("post_rst_dm_req", dm.Dm_req, 1'b0);
    check1("post_rst_stall", Stall, 1'b0);
    check("post_rst_w_rd", 32'(W_Rd), 32'd0);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Clk  in  1  sole clock; all state updates on rising edge.
REQ-002 Clrn  in  1  reset, asynchronous, active-low.
REQ-003 M_Op  in  6  opcode from EX/MEM register.
REQ-004 M_Wreg, M_Reg2reg, M_Wmem, M_Z  in  1 each  control/zero flag from EX/MEM; M_Reg2reg=0 means load (write-back from memory), 1 means ALU result.
REQ-005 Addr_in  in  32  ALU result / memory address; Sdata_in  in  32  store data; Rd_in  in  5  destination register; Bpc_in  in  32  branch target.
REQ-006 Dm_req, Dm_we  out  1  data-memory request, write enable; Dm_addr, Dm_wdata  out  32  address and write data.
REQ-007 Dm_rdata  in  32  read data; Dm_ack  in  1  access complete, rdata valid in the same cycle.
REQ-008 Stall  out  1  freezes upstream stages; drives EX/MEM We low.
REQ-009 Branch_taken  out  1; Branch_pc  out  32  redirect to fetch.
REQ-010 W_Wreg, W_Reg2reg  out  1; W_Rd  out  5; W_Alu, W_Mdata  out  32  MEM/WB register outputs.
REQ-011 Bus_err  out  1  sticky memory-timeout flag.
REQ-012 TIMEOUT parameter, default 255, cycles waited for Dm_ack before abort.

Function
REQ-013 Access = M_Wmem or (M_Wreg and not M_Reg2reg); M_Wmem and load together SHALL be treated as store only.
REQ-014 FSM states IDLE, BUSY; IDLE->BUSY when Access and not Dm_ack; BUSY->IDLE on Dm_ack or timeout.
REQ-015 Dm_req SHALL be 1 whenever Access is true in IDLE or state is BUSY; Dm_we=M_Wmem; Dm_addr=Addr_in; Dm_wdata=Sdata_in; all held stable while Dm_req=1 and Dm_ack=0.
REQ-016 Zero-wait access: Dm_ack in the request cycle completes without stall (latency 0 extra cycles).
REQ-017 Stall = Dm_req and not Dm_ack and not timeout-expiry; combinational.
REQ-018 Wait counter: cleared on entry to BUSY, increments each BUSY cycle; reaching TIMEOUT without ack SHALL end the access, set Bus_err, deassert Stall that cycle.
REQ-019 MEM/WB capture when Stall=0: W_Wreg<=M_Wreg, W_Reg2reg<=M_Reg2reg, W_Rd<=Rd_in, W_Alu<=Addr_in, W_Mdata<=Dm_rdata if load else hold previous.
REQ-020 While Stall=1, W_Wreg SHALL be 0 (bubble); other W_* hold.
REQ-021 Timed-out access: W_Wreg<=0 (instruction squashed), no register write.
REQ-022 Branch: beq=6'b000100 taken iff M_Z=1; bne=6'b000101 taken iff M_Z=0; Branch_taken combinational, gated by Stall=0; Branch_pc=Bpc_in.
REQ-023 Dm_ack while Dm_req=0 SHALL be ignored.
REQ-024 Bus_err remains 1 until reset; subsequent accesses proceed normally.

Reset
REQ-025 Clrn=0 SHALL immediately force state IDLE, counter 0, Bus_err 0, W_Wreg 0, W_Reg2reg 0, W_Rd 0, W_Alu 0, W_Mdata 0.
REQ-026 Reset during BUSY SHALL abandon the access; Dm_req falls with reset, no write-back.
REQ-027 Dm_req, Stall, Branch_taken SHALL be 0 while in reset only if Access inputs are 0 (upstream EX/MEM cleared by same Clrn).

Structure
REQ-028 Shared package holds opcode constants (beq, bne) and FSM state encoding.
REQ-029 MEM/WB register SHALL be a sub-module mem_wb with inputs We=not Stall, Clk, Clrn.

Verification
REQ-030 Load, Addr_in=0x100, Dm_ack same cycle, rdata=0xDEADBEEF -> Stall never 1; next cycle W_Mdata=0xDEADBEEF, W_Wreg=1.
REQ-031 Store, Sdata_in=0x12345678, ack after 3 cycles -> Stall=1 for 3 cycles, Dm_addr/wdata stable, W_Wreg=0 during stall, Dm_we=1.
REQ-032 Load, no ack, TIMEOUT=4 -> Stall high 4 cycles then low; Bus_err=1; W_Wreg=0.
REQ-033 beq with M_Z=1, Bpc_in=0x40 -> Branch_taken=1, Branch_pc=0x40; bne with M_Z=1 -> Branch_taken=0.
REQ-034 Clrn pulsed low mid-BUSY -> all registered outputs 0 asynchronously, state IDLE, no write-back after release.
